mem_arbiter: RTL

- Shares the single byte-wide unified RAM port between instruction fetch (IF stage, 32-bit reads at pc) and the MEM stage (byte/half/word loads and stores).
- Sequences each multi-byte access as consecutive single-byte RAM cycles and assembles or splits the data.
- Reports completion with one-cycle done pulses. The pipeline stall controller holds the requesting stage until its done pulse.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified byte-wide RAM port arbiter.
package mem_arbiter_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } state_t;

    // Number of RAM byte cycles for a MEM access; code 11 behaves as a word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LenByte: len_bytes = 3'd1;
            LenHalf: len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and MEM-stage accesses onto one byte-wide RAM
// port, splitting each access into consecutive single-byte RAM cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [31:0]       if_inst,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              ram_wr,
    output logic              busy
);

    state_t            state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    logic [2:0]        len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       buf_q, buf_nx;
    logic [1:0]        lane;
    logic              grant_if, grant_mem, finish_if, finish_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Reads spend one extra cycle after the last address to capture the
    // final byte; writes finish on the cycle of the last byte.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        finish_if  = 1'b0;
        finish_mem = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (mem_req && !mem_done) begin
                    grant_mem = 1'b1;
                    state_nx  = mem_we ? MEM_WR : MEM_RD;
                end else if (if_req && !if_done && !if_flush) begin
                    grant_if = 1'b1;
                    state_nx = IF_RD;
                end
            end
            IF_RD: begin
                if (if_flush) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == len_q) begin
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                    finish_if = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            MEM_RD: begin
                if (cnt == len_q) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    finish_mem = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            MEM_WR: begin
                if (cnt == len_q - 3'd1) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    finish_mem = 1'b1;
                end else begin
                    cnt_nx = cnt + 3'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Byte captured this cycle belongs to the address driven last cycle.
    // Fetch fills MSB-first, loads fill little-endian.
    always_comb begin
        buf_nx = buf_q;
        lane   = 2'(cnt - 3'd1);
        if ((state == IF_RD || state == MEM_RD) && cnt != 3'd0) begin
            if (state == IF_RD)
                buf_nx[{~lane, 3'b000} +: 8] = ram_din;
            else
                buf_nx[{lane, 3'b000} +: 8] = ram_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            len_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= ZeroWord;
            buf_q     <= ZeroWord;
            if_inst   <= ZeroWord;
            mem_rdata <= ZeroWord;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            if_done  <= finish_if;
            mem_done <= finish_mem;
            buf_q    <= (grant_if || grant_mem) ? ZeroWord : buf_nx;
            if (grant_mem) begin
                addr_q  <= mem_addr;
                len_q   <= len_bytes(mem_len);
                wdata_q <= mem_wdata;
            end else if (grant_if) begin
                addr_q <= if_addr;
                len_q  <= 3'd4;
            end
            if (finish_if)
                if_inst <= buf_nx;
            if (finish_mem && state == MEM_RD)
                mem_rdata <= buf_nx;
        end
    end

    assign busy     = (state != IDLE);
    assign ram_wr   = (state == MEM_WR);
    assign ram_a    = (state == IDLE) ? '0 : addr_q + ADDR_W'(cnt);
    assign ram_dout = (state == MEM_WR) ? wdata_q[{cnt[1:0], 3'b000} +: 8] : 8'h00;

endmodule
